// File: rtl/shift_sequencer.sv
// Command-driven sequencer for the 8-bit right-shift datapath: one load or N single-bit shifts per command.
// Optional rotate support is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] sh_q,
  output logic             sh_load_n,
  output logic             sh_shift,
  output logic [WIDTH-1:0] sh_load_val,
  output logic             sh_fill,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ASR   = 2'b10;
  localparam logic [1:0] OP_ROTR  = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] load_val_q, load_val_d;
  logic             accept;
  logic             fill;
  logic             unused_sh_q;

  assign accept = cmd_valid && (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    remaining_d = remaining_q;
    load_val_d  = load_val_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = cmd_op;
          if (cmd_op == OP_LOAD) begin
            load_val_d = cmd_data;
            state_d    = LOAD;
          end else if (cmd_count == '0) begin
            state_d = DONE;
          end else begin
            remaining_d = cmd_count;
            state_d     = SHIFT;
          end
        end
      end
      LOAD: state_d = DONE;
      SHIFT: begin
        remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_q        <= OP_LOAD;
      remaining_q <= '0;
      load_val_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      remaining_q <= remaining_d;
      load_val_q  <= load_val_d;
    end
  end

  // Fill bit follows the live datapath so it is correct for the shift on the coming edge.
  always_comb begin
    fill = 1'b0;
    if (state_q == SHIFT) begin
      case (op_q)
        OP_ASR:  fill = sh_q[WIDTH-1];
`ifdef SHIFT_SEQ_ROTATE_EN
        OP_ROTR: fill = sh_q[0];
`else
        OP_ROTR: fill = 1'b0;
`endif
        default: fill = 1'b0;
      endcase
    end
  end

  // Only the end bits of sh_q matter; the rest is fed back purely for visibility.
  assign unused_sh_q = ^sh_q;

  assign sh_fill     = fill;
  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign sh_load_n   = (state_q != LOAD);
  assign sh_shift    = (state_q == SHIFT);
  assign sh_load_val = load_val_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: pairs it with a behavioural right-shift register and checks timing and results.
// Expectations for op 11 follow SHIFT_SEQ_ROTATE_EN.
module tb_shift_sequencer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [WIDTH-1:0] sh_q;
  logic             sh_load_n;
  logic             sh_shift;
  logic [WIDTH-1:0] sh_load_val;
  logic             sh_fill;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] model_q = '0;
  int               check_count = 0;
  int               pass_count = 0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] count;
    logic [7:0] start;
    logic [7:0] expect_val;
  } vec_t;

  vec_t vectors[9];

  always #5 clock = ~clock;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .cmd_count   (cmd_count),
    .sh_q        (sh_q),
    .sh_load_n   (sh_load_n),
    .sh_shift    (sh_shift),
    .sh_load_val (sh_load_val),
    .sh_fill     (sh_fill),
    .busy        (busy),
    .done        (done)
  );

  // Behavioural datapath: never reset by the controller.
  always @(posedge clock) begin
    if (!sh_load_n) model_q <= sh_load_val;
    else if (sh_shift) model_q <= {sh_fill, model_q[7:1]};
  end
  assign sh_q = model_q;

  function automatic logic [7:0] ref_result(input logic [1:0] op, input logic [7:0] start,
                                            input logic [7:0] data, input int n);
    logic signed [7:0] s;
    logic [15:0]       dbl;
    s   = start;
    dbl = {start, start};
    case (op)
      2'b00: return data;
      2'b01: return start >> n;
      2'b10: return 8'(s >>> n);
`ifdef SHIFT_SEQ_ROTATE_EN
      default: begin
        dbl = dbl >> (n % 8);
        return dbl[7:0];
      end
`else
      default: return start >> n;
`endif
    endcase
  endfunction

  function automatic logic [5:0] exp_vec(input logic [1:0] op, input int count, input int c,
                                         input logic [7:0] dp);
    int   lat;
    logic ready, bsy, dn, shf, ldn, fil;
    lat   = (op == 2'b00) ? 2 : count + 1;
    ready = (c > lat);
    bsy   = (c <= lat);
    dn    = (c == lat);
    shf   = (op != 2'b00) && (c >= 1) && (c <= count);
    ldn   = !((op == 2'b00) && (c == 1));
    fil   = 1'b0;
    if (shf && op == 2'b10) fil = dp[7];
`ifdef SHIFT_SEQ_ROTATE_EN
    if (shf && op == 2'b11) fil = dp[0];
`endif
    return {ready, bsy, dn, shf, ldn, fil};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    checkOutput("reset_outputs", 16'({cmd_ready, busy, done, sh_shift, sh_load_n, sh_fill}), 16'b100010);
    checkOutput("reset_load_val", 16'(sh_load_val), 16'h0000);
  endtask

  // Issues one command and checks every cycle from accept until cmd_ready returns.
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] data, input int count,
                               input bit hold_busy);
    int lat;
    lat = (op == 2'b00) ? 2 : count + 1;
    @(negedge clock);
    checkOutput("ready_before", 16'(cmd_ready), 16'h0001);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = CNT_W'(count);
    @(posedge clock);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clock);
      if (c == 1) begin
        if (hold_busy) begin
          cmd_op    = 2'b00;
          cmd_data  = 8'h00;
          cmd_count = CNT_W'($urandom_range(0, 15));
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (c >= lat) cmd_valid = 1'b0;
      checkOutput($sformatf("timing_c%0d", c),
                  16'({cmd_ready, busy, done, sh_shift, sh_load_n, sh_fill}),
                  16'(exp_vec(op, count, c, model_q)));
    end
  endtask

  initial begin
    logic [7:0] start, data, expv, saved_val;
    logic [1:0] op;
    int         cnt;
    bit         hold;

    vectors[0] = '{op: 2'b00, count: 4'd0,  start: 8'h96, expect_val: 8'h96};
    vectors[1] = '{op: 2'b10, count: 4'd2,  start: 8'h96, expect_val: 8'hE5};
    vectors[2] = '{op: 2'b01, count: 4'd3,  start: 8'h96, expect_val: 8'h12};
`ifdef SHIFT_SEQ_ROTATE_EN
    vectors[3] = '{op: 2'b11, count: 4'd4,  start: 8'h96, expect_val: 8'h69};
    vectors[4] = '{op: 2'b11, count: 4'd8,  start: 8'hA5, expect_val: 8'hA5};
`else
    vectors[3] = '{op: 2'b11, count: 4'd4,  start: 8'h96, expect_val: 8'h09};
    vectors[4] = '{op: 2'b11, count: 4'd8,  start: 8'hA5, expect_val: 8'h00};
`endif
    vectors[5] = '{op: 2'b01, count: 4'd0,  start: 8'h96, expect_val: 8'h96};
    vectors[6] = '{op: 2'b10, count: 4'd15, start: 8'h96, expect_val: 8'hFF};
    vectors[7] = '{op: 2'b01, count: 4'd8,  start: 8'hFF, expect_val: 8'h00};
    vectors[8] = '{op: 2'b10, count: 4'd1,  start: 8'h41, expect_val: 8'h20};

    for (int i = 0; i < 9; i++) begin
      do_reset();
      applyStimulus(2'b00, vectors[i].start, 0, 1'b0);
      checkOutput($sformatf("load_model_%0d", i), 16'(model_q), 16'(vectors[i].start));
      if (vectors[i].op != 2'b00) applyStimulus(vectors[i].op, 8'h3C, int'(vectors[i].count), 1'b0);
      checkOutput($sformatf("vec_result_%0d", i), 16'(model_q), 16'(vectors[i].expect_val));
      checkOutput($sformatf("vec_load_val_%0d", i), 16'(sh_load_val), 16'(vectors[i].start));
    end

    // cmd_valid held high with a load of 0x00 while busy must not be taken.
    do_reset();
    applyStimulus(2'b00, 8'h96, 0, 1'b0);
    applyStimulus(2'b01, 8'h55, 5, 1'b1);
    checkOutput("busy_valid_model", 16'(model_q), 16'h0004);
    checkOutput("busy_valid_load_val", 16'(sh_load_val), 16'h0096);

    // Reset during the third shift of a count-10 command.
    do_reset();
    applyStimulus(2'b00, 8'h96, 0, 1'b0);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_count = 4'd10;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("midop_shift3", 16'({sh_shift, done}), 16'b10);
    reset_n = 1'b0;
    @(negedge clock);
    checkOutput("midop_after_reset", 16'({cmd_ready, busy, done, sh_shift, sh_load_n, sh_fill}), 16'b100010);
    checkOutput("midop_model", 16'(model_q), 16'h0012);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkOutput("midop_no_done", 16'({done, busy}), 16'b00);
      checkOutput("midop_model_hold", 16'(model_q), 16'h0012);
    end

    // Randomized commands against the arithmetic reference.
    do_reset();
    for (int r = 0; r < 40; r++) begin
      start = 8'($urandom);
      data  = 8'($urandom);
      op    = 2'($urandom_range(0, 3));
      cnt   = $urandom_range(0, 15);
      hold  = 1'($urandom_range(0, 1));
      applyStimulus(2'b00, start, 0, 1'b0);
      saved_val = sh_load_val;
      expv = ref_result(op, start, data, cnt);
      applyStimulus(op, data, cnt, hold);
      checkOutput($sformatf("rand_result_%0d", r), 16'(model_q), 16'(expv));
      checkOutput($sformatf("rand_load_val_%0d", r), 16'(sh_load_val),
                  16'((op == 2'b00) ? data : saved_val));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
